// File: rtl/dr_sync_tx.sv
// dr_sync_tx: clocked producer that injects dual-rail four-phase RZ tokens into an async pipeline.
// Optional sticky stall flag when DR_TX_TIMEOUT_EN is defined.
module dr_sync_tx #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [2*WIDTH-1:0] data_out,
   input  logic               ack_next,
   output logic               busy,
   output logic               err
);
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [2*WIDTH-1:0] data_out_q, data_out_d, code;
   logic in_ready_q, in_ready_d, busy_q, ack_s, accept;
   assign ack_s    = sync_q[SYNC_STAGES-1];
   assign accept   = in_valid && in_ready_q;
   assign in_ready = in_ready_q;
   assign data_out = data_out_q;
   assign busy     = busy_q;
   always_comb begin
      code = '0;
      for (int i = 0; i < WIDTH; i++) code[2*i +: 2] = {in_data[i], ~in_data[i]};
   end
   // in_ready_q can only be high in IDLE, so accept alone marks the launch edge
   always_comb begin
      state_d    = state_q == S_IDLE ? (accept ? S_DATA : S_IDLE)
                 : state_q == S_DATA ? (ack_s ? S_NULL : S_DATA)
                 : (ack_s ? S_NULL : S_IDLE);
      data_out_d = accept ? code : state_d == S_DATA ? data_out_q : '0;
      in_ready_d = state_d == S_IDLE && !ack_s;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync_q     <= '1;
         data_out_q <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], ack_next};
         data_out_q <= data_out_d;
         in_ready_q <= in_ready_d;
         busy_q     <= state_d != S_IDLE;
      end
   end
`ifdef DR_TX_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q;
   always_comb begin
      cnt_d = state_d != state_q ? '0
            : (state_q != S_IDLE && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_q | (cnt_d == CW'(TIMEOUT));
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_dr_sync_tx.sv
// tb_dr_sync_tx: randomized bench for dr_sync_tx with a behavioural reference model and a
// reactive model of the first pipeline stage's acknowledge.
module tb_dr_sync_tx;
   localparam int W  = 8;
   localparam int S  = 2;
   localparam int TO = 10;
   logic clk = 0, rst = 0;
   logic [W-1:0] in_data = '0;
   logic in_valid = 0;
   logic in_ready, busy, err;
   logic [2*W-1:0] data_out;
   logic ack_auto = 0, ack_man = 0, pipe_en = 0;
   wire  ack_next = pipe_en ? ack_auto : ack_man;
   int checks = 0, errors = 0;
   bit started = 0;
   int ack_delay = 0;

   dr_sync_tx #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .data_out(data_out), .ack_next(ack_next), .busy(busy), .err(err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] enc(input logic [W-1:0] d);
      logic [2*W-1:0] r = '0;
      for (int i = 0; i < W; i++) r = r | ((2*W)'(d[i] ? 2 : 1) << (2*i));
      return r;
   endfunction

   function automatic bit has11(input logic [2*W-1:0] v);
      for (int i = 0; i < W; i++) if (v[2*i] && v[2*i+1]) return 1;
      return 0;
   endfunction

   // Reference model: the acknowledge is seen S edges late; a token is issued, held
   // until the late ack is high, then spacer until the late ack is low again.
   bit ackq[$];
   int m_phase, m_prev, m_cnt;
   logic [2*W-1:0] m_data;
   logic m_ready, m_busy, m_err;
   bit a;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ackq = {};
         for (int i = 0; i < S; i++) ackq.push_back(1'b1);
         m_phase = 0; m_data = '0; m_ready = 0; m_busy = 0; m_err = 0; m_cnt = 0;
      end else begin
         a = ackq[0];
         m_prev = m_phase;
         if (m_phase == 0 && m_ready && in_valid) begin
            m_data = enc(in_data); m_phase = 1;
         end else if (m_phase == 1 && a) begin
            m_data = '0; m_phase = 2;
         end else if (m_phase == 2 && !a) m_phase = 0;
         m_ready = m_phase == 0 && !a;
         m_busy  = m_phase != 0;
`ifdef DR_TX_TIMEOUT_EN
         if (m_phase != m_prev) m_cnt = 0;
         else if (m_phase != 0 && m_cnt < TO) m_cnt++;
         if (m_cnt == TO) m_err = 1;
`endif
         void'(ackq.pop_front());
         ackq.push_back(ack_next);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("data_out", data_out, m_data);
         chk("in_ready", in_ready, m_ready);
         chk("busy", busy, m_busy);
         chk("err", err, m_err);
         chk("rail11", has11(data_out), 0);
      end
   end

   // Transaction monitor: codeword hold length and accept-to-accept spacing
   logic [2*W-1:0] prev_do = '0;
   int hold = 0, last_hold = 0, cyc = 0, prev_acc = -1, last_int = 0;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_do = '0; hold = 0; prev_acc = -1;
      end else begin
         if (data_out != 0) hold = (data_out == prev_do) ? hold + 1 : 1;
         if (data_out == 0 && prev_do != 0) last_hold = hold;
         prev_do = data_out;
         if (in_valid && in_ready) begin
            if (prev_acc >= 0) begin
               last_int = cyc - prev_acc;
               chk("interval_min", last_int >= 7, 1);
            end
            prev_acc = cyc;
         end
      end
   end

   int pcnt = 0;
   initial begin
      forever begin
         @(posedge clk); #2;
         if (ack_auto != (data_out != 0)) begin
            if (pcnt >= ack_delay) begin ack_auto = data_out != 0; pcnt = 0; end
            else pcnt++;
         end else pcnt = 0;
      end
   end

   task automatic send(input logic [W-1:0] d, input bit keep);
      int n = 0;
      in_data = d; in_valid = 1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         if (++n > 300) begin chk("accept_timeout", 0, 1); break; end
      end
      @(posedge clk); #2;
      if (!keep) in_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while ((busy || !in_ready) && n < 400);
      if (n >= 400) chk("idle_timeout", 0, 1);
      @(posedge clk); #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1 rst = 1; started = 1;
      #1 chk("rst_data_out", data_out, 0);
      chk("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #2 rst = 0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #3;
         chk("post_rst_ready", in_ready, k == 3);
      end
      @(posedge clk); #2;
      pipe_en = 1; ack_delay = 0;
      send(8'hA5, 0);
      chk("a5_code", data_out, 16'b1001100101100110);
      send(8'h3C, 0);
      chk("a5_interval", last_int, 7);
      chk("a5_hold", last_hold, 3);
      wait_idle();
      send(8'h00, 1);
      chk("b2b_00", data_out, 16'h5555);
      send(8'hFF, 1);
      chk("b2b_ff", data_out, 16'hAAAA);
      in_valid = 0;
      wait_idle();
      for (int n = 0; n < 60; n++) begin
         ack_delay = $urandom_range(0, 4);
         send(W'($urandom), 0);
         repeat ($urandom_range(0, 3)) begin in_data = W'($urandom); @(posedge clk); #2; end
      end
      wait_idle();
      ack_delay = 20; last_hold = 0;
      send(8'h69, 0);
      repeat (25) begin @(posedge clk); #2; in_data = W'($urandom); end
      wait_idle();
      chk("slow_hold", last_hold >= 20, 1);
      ack_delay = 0;
      pipe_en = 0; ack_man = 0;
      send(8'h5A, 0);
      repeat (15) @(posedge clk);
      #3;
`ifdef DR_TX_TIMEOUT_EN
      chk("stall_err", err, 1);
`else
      chk("stall_err", err, 0);
`endif
      ack_man = 1;
      begin
         int n = 0;
         do begin @(negedge clk); n++; end while (data_out != 0 && n < 50);
         chk("stall_spacer", data_out, 0);
      end
      ack_man = 0;
      wait_idle();
      send(8'hC3, 0);
      ack_man = 1;
      @(posedge clk); #3;
      rst = 1;
      #1 chk("mid_rst_data_out", data_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", in_ready, 0);
      @(posedge clk); #2 rst = 0;
      repeat (5) begin @(posedge clk); #3; chk("ack_high_ready", in_ready, 0); end
      ack_man = 0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #3;
         chk("ack_low_ready", in_ready, k == 3);
      end
      repeat (3) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
